// File: rtl/uart_receiver.sv
`timescale 1ns / 1ps
// uart_receiver: UART 8N1 receive path.
//   Synchronises the asynchronous rx line, detects the start-bit falling edge
//   and samples every bit, including the stop bit, at mid-bit.
// Ports:
//   clk          system clock, all state changes on posedge
//   reset        asynchronous, active-low reset (0 = reset)
//   rx           serial input, idle high, asynchronous to clk
//   data   [7:0] last correctly framed byte, LSB received first
//   valid        1-cycle pulse when data is updated
//   frame_error  1-cycle pulse when the stop bit is sampled low
//   busy         high whenever the receiver is not idle
module uart_receiver #(
  parameter int unsigned NATIVE_CLK_FREQUENCY = 50_000_000,
  parameter int unsigned TARGET_CLK_FREQUENCY = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = NATIVE_CLK_FREQUENCY / TARGET_CLK_FREQUENCY;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  // Width floor keeps the counter legal while the ratio check reports a bad setup.
  localparam int unsigned CNT_W        = (CLKS_PER_BIT < 4) ? 2 : $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = 3;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  if (CLKS_PER_BIT < 4) begin : g_bad_ratio
    $error("uart_receiver: CLKS_PER_BIT must be >= 4");
  end

  logic             rx_m, rx_s, rx_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_d;
  logic             valid_d, frame_error_d;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      data        <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      data        <= data_d;
      valid       <= valid_d;
      frame_error <= frame_error_d;
      busy        <= (state_d != IDLE);
    end
  end

  // Next-state, counter and strobe logic; every reload happens at cnt==0.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shreg_d       = shreg_q;
    data_d        = data;
    valid_d       = 1'b0;
    frame_error_d = 1'b0;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        if (rx_q && !rx_s) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = CNT_FULL;
            idx_d   = '0;
          end else begin
            // Start bit gone by mid-bit: treat as a glitch.
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d[idx_q] = rx_s;
          cnt_d          = CNT_FULL;
          if (idx_q == IDX_W'(7)) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (cnt_q == '0) begin
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low (break) line must rise before a new frame can start.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns / 1ps
// tb_uart_receiver: scoreboard bench for uart_receiver at 16 clk per bit.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT = 2 + HALF + 9 * CPB + 1;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       busy;

  int   checks;
  int   errors;
  int   cyc;
  exp_t sb[$];
  logic [7:0] last_good;

  uart_receiver #(
    .NATIVE_CLK_FREQUENCY(16),
    .TARGET_CLK_FREQUENCY(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Drives one 8N1 frame starting at a negedge; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    exp_t e;
    @(negedge clk);
    rx    = 1'b0;
    e.cyc = cyc + LAT;
    e.ferr = !stop_bit;
    if (stop_bit) last_good = b;
    e.data = last_good;
    sb.push_back(e);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB - 1);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && (valid || frame_error)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: valid=%0b frame_error=%0b data=%h at cycle %0d",
                 valid, frame_error, data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (valid !== !e.ferr || frame_error !== e.ferr || data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL strobe: got valid=%0b frame_error=%0b data=%h cycle=%0d expected valid=%0b frame_error=%0b data=%h cycle=%0d",
                   valid, frame_error, data, cyc, !e.ferr, e.ferr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    int fall;
    logic bad;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    last_good = 8'h00;
    reset     = 1'b0;
    rx        = 1'b1;
    tick(4);
    check("reset_data", data, 8'h00);
    check("reset_strobes", {5'b0, valid, frame_error, busy}, 8'h00);
    reset = 1'b1;

    // Idle line: no activity at all.
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (valid || frame_error || busy) bad = 1'b1;
    end
    check("idle_quiet", {7'b0, bad}, 8'h00);

    // Single frame.
    send_frame(8'hA5, 1'b1);
    tick(1);
    check("a5_busy_fall", {7'b0, busy}, 8'h00);
    check("a5_data", data, 8'hA5);
    tick(20);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(1);
    check("ff_data", data, 8'hFF);
    tick(20);

    // Short glitch rejected by START.
    @(negedge clk);
    rx   = 1'b0;
    fall = cyc;
    tick(4);
    rx = 1'b1;
    tick(fall + HALF + 2 - cyc);
    check("glitch_busy_high", {7'b0, busy}, 8'h01);
    tick(1);
    check("glitch_busy_low", {7'b0, busy}, 8'h00);
    check("glitch_data", data, 8'hFF);
    tick(20);

    // Bad stop bit followed by a 40-cycle break.
    send_frame(8'h3C, 1'b0);
    tick(40);
    check("break_busy", {7'b0, busy}, 8'h01);
    check("break_data", data, 8'hFF);
    rx = 1'b1;
    tick(4);
    check("break_release_busy", {7'b0, busy}, 8'h00);
    tick(20);

    // Asynchronous reset in the middle of bit 4 of 0x5A.
    @(negedge clk);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h5A >> i) & 8'h01;
      tick(CPB);
    end
    rx = 1'b1;
    tick(HALF);
    check("pre_reset_busy", {7'b0, busy}, 8'h01);
    #0.5 reset = 1'b0;
    #0.2;
    check("async_reset_data", data, 8'h00);
    check("async_reset_strobes", {5'b0, valid, frame_error, busy}, 8'h00);
    last_good = 8'h00;
    tick(3);
    reset = 1'b1;
    tick(10);
    check("post_reset_busy", {7'b0, busy}, 8'h00);
    send_frame(8'h81, 1'b1);
    tick(1);
    check("81_data", data, 8'h81);
    tick(20);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: %0d outstanding, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish by 20000 ns");
    $fatal(1, "timeout");
  end

endmodule
